// File: rtl/axis_radar_segment_scheduler.sv
// Segment scheduler for the quarter-buffer radar RAM reader: queues {quarter, len} commands,
// arms cfg_data and advances on reader wrap. Optional replay-on-starve via AXIS_RADAR_SCHED_LOOP_EN.
module axis_radar_segment_scheduler #(
    parameter int ADDR_WIDTH   = 16,
    parameter int IDLE_QUARTER = 3,
    parameter int IDLE_LEN     = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  run,
    input  logic                  flush,
    input  logic [1:0]            cmd_quarter,
    input  logic [ADDR_WIDTH-3:0] cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cfg_data,
    input  logic [ADDR_WIDTH-1:0] sts_data,
    output logic [3:0]            busy_mask,
    output logic [1:0]            active_quarter,
    output logic                  seg_done,
    output logic [1:0]            seg_done_quarter,
    output logic [15:0]           underrun_count,
    output logic [CNT_WIDTH-1:0]  pulse_count
);

    localparam int LW = ADDR_WIDTH - 2;

    typedef struct packed {
        logic [1:0]    quarter;
        logic [LW-1:0] len;
    } seg_t;

    localparam logic [1:0]    IDLE_Q   = 2'(IDLE_QUARTER);
    localparam seg_t          IDLE_SEG = {IDLE_Q, LW'(IDLE_LEN)};

    seg_t                 queue_q [3];
    seg_t                 queue_d [3];
    logic [1:0]           count_q, count_d;
    seg_t                 armed_q, armed_d;
    seg_t                 active_q, active_d;
    logic [LW-1:0]        prev_low_q, prev_low_d;
    logic                 seg_done_q, seg_done_d;
    logic [1:0]           seg_done_quarter_q, seg_done_quarter_d;
    logic [15:0]          underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0] pulse_q, pulse_d;

    logic       wrap;
    logic       push;
    logic       pop;
    logic [1:0] count_pop;
    seg_t       new_entry;
    logic       sts_unused;

    assign sts_unused = ^sts_data[ADDR_WIDTH-1:LW];

    // Stale slots beyond count_q are ignored so a flush needs only to clear the count.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < count_q) begin
                busy_mask[queue_q[i].quarter] = 1'b1;
            end
        end
        busy_mask[armed_q.quarter]  = 1'b1;
        busy_mask[active_q.quarter] = 1'b1;
        busy_mask[IDLE_Q]           = 1'b0;
    end

    assign cmd_ready = ~flush & (cmd_quarter != IDLE_Q) & ~busy_mask[cmd_quarter]
                     & (count_q != 2'd3);
    assign wrap      = (sts_data[LW-1:0] == '0) & (prev_low_q != '0);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = wrap & run & (count_q != 2'd0);
    assign new_entry = {cmd_quarter, (cmd_len == '0) ? LW'(1) : cmd_len};

    always_comb begin
        queue_d            = queue_q;
        count_d            = count_q;
        armed_d            = armed_q;
        active_d           = active_q;
        prev_low_d         = sts_data[LW-1:0];
        seg_done_d         = 1'b0;
        seg_done_quarter_d = seg_done_quarter_q;
        underrun_d         = underrun_q;
        pulse_d            = pulse_q;

        // Pop uses pre-push contents, so an entry pushed into an empty queue waits a wrap.
        if (pop) begin
            queue_d[0] = queue_q[1];
            queue_d[1] = queue_q[2];
        end
        count_pop = count_q - {1'b0, pop};
        for (int i = 0; i < 3; i++) begin
            if (push && (2'(i) == count_pop)) begin
                queue_d[i] = new_entry;
            end
        end
        count_d = count_pop + {1'b0, push};
        if (flush) begin
            count_d = '0;
        end

        if (wrap) begin
            active_d = armed_q;
            if ((active_q.quarter != IDLE_Q) && (active_q.quarter != armed_q.quarter)) begin
                seg_done_d         = 1'b1;
                seg_done_quarter_d = active_q.quarter;
            end
            if (pop) begin
                armed_d = queue_q[0];
`ifdef AXIS_RADAR_SCHED_LOOP_EN
            end else if (!run) begin
                armed_d = IDLE_SEG;
`else
            end else begin
                armed_d = IDLE_SEG;
`endif
            end
            if (run && (count_q == 2'd0) && (underrun_q != '1)) begin
                underrun_d = underrun_q + 16'd1;
            end
            if (armed_q.quarter != IDLE_Q) begin
                pulse_d = pulse_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < 3; i++) begin
                queue_q[i] <= IDLE_SEG;
            end
            count_q            <= '0;
            armed_q            <= IDLE_SEG;
            active_q           <= IDLE_SEG;
            prev_low_q         <= '0;
            seg_done_q         <= 1'b0;
            seg_done_quarter_q <= '0;
            underrun_q         <= '0;
            pulse_q            <= '0;
        end else begin
            queue_q            <= queue_d;
            count_q            <= count_d;
            armed_q            <= armed_d;
            active_q           <= active_d;
            prev_low_q         <= prev_low_d;
            seg_done_q         <= seg_done_d;
            seg_done_quarter_q <= seg_done_quarter_d;
            underrun_q         <= underrun_d;
            pulse_q            <= pulse_d;
        end
    end

    assign cfg_data         = armed_q;
    assign active_quarter   = active_q.quarter;
    assign seg_done         = seg_done_q;
    assign seg_done_quarter = seg_done_quarter_q;
    assign underrun_count   = underrun_q;
    assign pulse_count      = pulse_q;

endmodule

// File: tb/tb_axis_radar_segment_scheduler.sv
// Bench for axis_radar_segment_scheduler: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations (honours AXIS_RADAR_SCHED_LOOP_EN).
module tb_axis_radar_segment_scheduler;

    localparam int AW = 16;
    localparam int LW = AW - 2;
`ifdef AXIS_RADAR_SCHED_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          run = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    cmd_quarter = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cfg_data;
    logic [AW-1:0] sts_data = '0;
    logic [3:0]    busy_mask;
    logic [1:0]    active_quarter;
    logic          seg_done;
    logic [1:0]    seg_done_quarter;
    logic [15:0]   underrun_count;
    logic [31:0]   pulse_count;

    int n_checks = 0;
    int n_fail   = 0;

    axis_radar_segment_scheduler #(
        .ADDR_WIDTH(AW), .IDLE_QUARTER(3), .IDLE_LEN(1), .CNT_WIDTH(32)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .run(run), .flush(flush),
        .cmd_quarter(cmd_quarter), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cfg_data(cfg_data), .sts_data(sts_data),
        .busy_mask(busy_mask), .active_quarter(active_quarter), .seg_done(seg_done),
        .seg_done_quarter(seg_done_quarter), .underrun_count(underrun_count),
        .pulse_count(pulse_count)
    );

    always #5 aclk = ~aclk;

    // Reference model: software-visible segment queue plus what is armed and playing.
    typedef struct {
        int q;
        int len;
    } mseg_t;

    localparam mseg_t IDLE_M = '{3, 1};

    mseg_t m_queue[$];
    mseg_t m_armed  = '{3, 1};
    mseg_t m_active = '{3, 1};
    int    m_underrun = 0;
    int    m_pulse = 0;
    int    m_prev = 0;
    bit    m_done = 1'b0;
    int    m_done_q = 0;

    function automatic logic [3:0] model_busy();
        logic [3:0] m;
        m = '0;
        foreach (m_queue[i]) m[m_queue[i].q] = 1'b1;
        m[m_armed.q]  = 1'b1;
        m[m_active.q] = 1'b1;
        m[3] = 1'b0;
        return m;
    endfunction

    function automatic bit model_ready(input int q);
        logic [3:0] b;
        b = model_busy();
        return !flush && (q != 3) && !b[q] && (m_queue.size() < 3);
    endfunction

    always @(posedge aclk) begin
        bit    wrap;
        bit    accept;
        bit    empty;
        mseg_t old;
        if (!aresetn) begin
            m_queue.delete();
            m_armed    = IDLE_M;
            m_active   = IDLE_M;
            m_underrun = 0;
            m_pulse    = 0;
            m_prev     = 0;
            m_done     = 1'b0;
            m_done_q   = 0;
        end else begin
            wrap   = (int'(sts_data[LW-1:0]) == 0) && (m_prev != 0);
            accept = cmd_valid && model_ready(int'(cmd_quarter));
            empty  = (m_queue.size() == 0);
            m_done = 1'b0;
            if (wrap) begin
                old      = m_active;
                m_active = m_armed;
                if (old.q != 3 && old.q != m_active.q) begin
                    m_done   = 1'b1;
                    m_done_q = old.q;
                end
                if (run && !empty) m_armed = m_queue.pop_front();
                else if (!(LOOP && run)) m_armed = IDLE_M;
                if (run && empty && m_underrun < 65535) m_underrun++;
                if (m_active.q != 3) m_pulse++;
            end
            if (accept) m_queue.push_back('{int'(cmd_quarter), (cmd_len == '0) ? 1 : int'(cmd_len)});
            if (flush) m_queue.delete();
            m_prev = int'(sts_data[LW-1:0]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle out of reset, the DUT must agree with the model.
    always @(negedge aclk) begin
        logic [AW-1:0] exp_cfg;
        if (aresetn) begin
            exp_cfg = {2'(m_armed.q), LW'(m_armed.len)};
            checkOutput("cfg_data", 32'(cfg_data), 32'(exp_cfg));
            checkOutput("busy_mask", 32'(busy_mask), 32'(model_busy()));
            checkOutput("active_quarter", 32'(active_quarter), 32'(m_active.q));
            checkOutput("seg_done", 32'(seg_done), 32'(m_done));
            if (m_done) checkOutput("seg_done_quarter", 32'(seg_done_quarter), 32'(m_done_q));
            checkOutput("underrun_count", 32'(underrun_count), 32'(m_underrun));
            checkOutput("pulse_count", pulse_count, 32'(m_pulse));
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(model_ready(int'(cmd_quarter))));
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [LW-1:0] low, input logic fl, input logic v,
                                 input logic [1:0] q, input logic [LW-1:0] len);
        sts_data    = {2'b11, low};
        flush       = fl;
        cmd_valid   = v;
        cmd_quarter = q;
        cmd_len     = len;
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic wrapOnce();
        applyStimulus(LW'(1), 1'b0, 1'b0, 2'd0, '0);
        applyStimulus(LW'(0), 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic pushCmd(input logic [1:0] q, input logic [LW-1:0] len);
        applyStimulus(LW'(0), 1'b0, 1'b1, q, len);
    endtask

    task automatic probeReady(input logic [1:0] q, input logic exp);
        cmd_quarter = q;
        cmd_valid   = 1'b1;
        #1;
        checkOutput("cmd_ready_probe", 32'(cmd_ready), 32'(exp));
        cmd_valid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        #1;
        checkOutput("reset_cfg", 32'(cfg_data), 32'hC001);
        checkOutput("reset_busy", 32'(busy_mask), 32'h0);
        checkOutput("reset_active", 32'(active_quarter), 32'd3);
        checkOutput("reset_seg_done", 32'(seg_done), 32'd0);
        checkOutput("reset_underrun", 32'(underrun_count), 32'd0);
        checkOutput("reset_pulse", pulse_count, 32'd0);

        $display("[TB] idle wrap with run low");
        run = 1'b0;
        applyStimulus(LW'(0), 1'b0, 1'b0, 2'd0, '0);
        wrapOnce();
        checkOutput("idle_cfg", 32'(cfg_data), 32'hC001);
        checkOutput("idle_seg_done", 32'(seg_done), 32'd0);
        checkOutput("idle_underrun", 32'(underrun_count), 32'd0);

        $display("[TB] q0 then q1 playback");
        run = 1'b1;
        probeReady(2'd0, 1'b1);
        pushCmd(2'd0, LW'(5));
        wrapOnce();
        checkOutput("armed_q0_cfg", 32'(cfg_data), 32'h0005);
        checkOutput("armed_q0_busy", 32'(busy_mask), 32'h1);
        pushCmd(2'd1, LW'(3));
        probeReady(2'd0, 1'b0);
        probeReady(2'd3, 1'b0);
        wrapOnce();
        checkOutput("q0_active", 32'(active_quarter), 32'd0);
        checkOutput("q0_pulse", pulse_count, 32'd1);
        checkOutput("q1_armed_cfg", 32'(cfg_data), 32'h4003);
        probeReady(2'd0, 1'b0);
        wrapOnce();
        checkOutput("q0_done", 32'(seg_done), 32'd1);
        checkOutput("q0_done_quarter", 32'(seg_done_quarter), 32'd0);
        checkOutput("q1_busy", 32'(busy_mask), 32'h2);
        checkOutput("starve_underrun", 32'(underrun_count), 32'd1);
        checkOutput("starve_cfg", 32'(cfg_data), LOOP ? 32'h4003 : 32'hC001);
        applyStimulus(LW'(0), 1'b0, 1'b0, 2'd0, '0);
        checkOutput("done_one_cycle", 32'(seg_done), 32'd0);

        $display("[TB] drain to idle with run low");
        run = 1'b0;
        repeat (3) wrapOnce();
        checkOutput("drain_busy", 32'(busy_mask), 32'h0);
        checkOutput("drain_active", 32'(active_quarter), 32'd3);
        checkOutput("drain_underrun", 32'(underrun_count), 32'd1);
        checkOutput("drain_pulse", pulse_count, LOOP ? 32'd3 : 32'd2);

        $display("[TB] fill queue, clamp, flush on wrap");
        run = 1'b1;
        probeReady(2'd0, 1'b1);
        pushCmd(2'd0, LW'(0));
        probeReady(2'd1, 1'b1);
        pushCmd(2'd1, LW'(2));
        probeReady(2'd2, 1'b1);
        pushCmd(2'd2, LW'(7));
        probeReady(2'd2, 1'b0);
        probeReady(2'd0, 1'b0);
        checkOutput("full_busy", 32'(busy_mask), 32'h7);
        wrapOnce();
        checkOutput("clamp_cfg", 32'(cfg_data), 32'h0001);
        applyStimulus(LW'(1), 1'b0, 1'b0, 2'd0, '0);
        applyStimulus(LW'(0), 1'b1, 1'b0, 2'd0, '0);
        checkOutput("flush_cfg", 32'(cfg_data), 32'h4002);
        checkOutput("flush_busy", 32'(busy_mask), 32'h3);
        checkOutput("flush_active", 32'(active_quarter), 32'd0);

        $display("[TB] push on a starved wrap");
        applyStimulus(LW'(1), 1'b0, 1'b0, 2'd0, '0);
        applyStimulus(LW'(0), 1'b0, 1'b1, 2'd2, LW'(4));
        checkOutput("pushwrap_active", 32'(active_quarter), 32'd1);
        checkOutput("pushwrap_done_q", 32'(seg_done_quarter), 32'd0);
        checkOutput("pushwrap_underrun", 32'(underrun_count), 32'd2);
        checkOutput("pushwrap_cfg", 32'(cfg_data), LOOP ? 32'h4002 : 32'hC001);
        checkOutput("pushwrap_busy", 32'(busy_mask), 32'h6);
        wrapOnce();
        checkOutput("q2_armed_cfg", 32'(cfg_data), 32'h8004);

        run = 1'b0;
        repeat (3) wrapOnce();
        checkOutput("final_busy", 32'(busy_mask), 32'h0);
        checkOutput("final_active", 32'(active_quarter), 32'd3);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_radar_segment_scheduler.md
Name: axis_radar_segment_scheduler

Overview:
- Sequences playback segments for the radar RAM reader (quarter-buffer player).
- Software queues "quarter q loaded, play len+1 bursts" commands. The block presents the reader's cfg_data (quarter in the top 2 bits, end index in the low bits) and detects segment wrap from the reader's sts_data.
- At each wrap it advances to the next queued segment and releases the finished quarter back to software.
- An idle quarter holding zeros is played whenever nothing is queued or run is low.

Parameters:
- ADDR_WIDTH, 16, reader address width; the low ADDR_WIDTH-2 bits are the in-quarter burst index.
- IDLE_QUARTER, 3, reserved quarter played when idle; commands targeting it are rejected.
- IDLE_LEN, 1, end index used for the idle segment; must be ≥1.
- CNT_WIDTH, 32, width of pulse_count.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- run  in  1  1 = consume queue; 0 = switch to idle at the next wrap
- flush  in  1  pulse; discards queued, not-yet-armed commands
- cmd_quarter  in  2  target quarter of the command
- cmd_len  in  ADDR_WIDTH-2  segment end index; 0 is clamped to 1
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept
- cfg_data  out  ADDR_WIDTH  to reader cfg_data
- sts_data  in  ADDR_WIDTH  from reader sts_data
- busy_mask  out  4  quarters queued, armed or active (idle quarter excluded)
- active_quarter  out  2  quarter currently played
- seg_done  out  1  one-cycle pulse, quarter released
- seg_done_quarter  out  2  quarter released; valid with seg_done
- underrun_count  out  16  saturating count of starved wraps
- pulse_count  out  CNT_WIDTH  wrapping count of non-idle segments started

Behaviour:
- Reset is synchronous on aresetn low, all state cleared:
  - queue empty;
  - armed = active = {IDLE_QUARTER, IDLE_LEN}; cfg_data = {IDLE_QUARTER, IDLE_LEN};
  - counters 0; seg_done 0; busy_mask 0; prev_low 0.
- Internal state:
  - 3-entry FIFO queue of {quarter, len};
  - armed register, which drives cfg_data and is what the reader latches at its next wrap;
  - active register, the segment the reader is playing.
- Command accept:
  - cmd_ready = ~flush & (cmd_quarter != IDLE_QUARTER) & ~busy_mask[cmd_quarter] & queue not full.
  - On cmd_valid & cmd_ready the entry is pushed and the busy bit is set in the same cycle (visible next cycle).
- Wrap detect:
  - prev_low is registered from sts_data[ADDR_WIDTH-3:0] every cycle.
  - wrap = (sts_data low bits == 0) & (prev_low != 0). It is combinational and fires for one cycle.
- On a wrap cycle, all updates below take effect at the same edge:
  - active <= armed.
  - If the old active is non-idle and differs from the new active quarter: seg_done = 1 and seg_done_quarter = old active quarter (registered, one cycle); its busy bit clears.
  - If run & queue non-empty: armed <= pop. Otherwise armed <= idle (see Optional Feature).
  - If run & queue empty: underrun_count++, saturating at 0xFFFF.
  - If the new active is non-idle: pulse_count++, wrapping.
- cfg_data changes only on the edge after a wrap. With len ≥1 the reader's next latch is at least 2 edges later, so there is no race.
- Simultaneous events:
  - Push and pop in the same wrap cycle are both honoured. When the queue was empty, the pushed entry is not popped this wrap.
  - flush in the same cycle as wrap: the pop happens first from pre-flush contents, then the remaining entries are discarded.
  - flush clears the busy bits of discarded quarters only; armed and active are untouched.
- run low mid-segment: the current segment and any already-armed segment complete. At the next wrap armed becomes idle and no underrun is counted.
- busy_mask = OR of queue entries, armed and active quarters, excluding IDLE_QUARTER.

Optional Feature:
- Macro AXIS_RADAR_SCHED_LOOP_EN.
- Defined: on a wrap with run=1 and the queue empty, armed keeps its current non-idle value, replaying the last segment. The quarter is not released because old active == new active. Underrun is still counted.
- Not defined: armed falls back to idle.

Test Plan:
- Reset, then drive sts_data through {3,0},{3,1},{3,0} (IDLE_QUARTER=3, IDLE_LEN=1) → cfg_data=0xC001, no seg_done, underrun_count=0 (run=0).
- run=1, push q0 len 5, then the reader wraps once → cfg_data=0x0005 held until the next wrap. Next wrap: active_quarter=0, pulse_count=1.
- Continuing from the previous test, push q1 len 3, let q0 play out to wrap → seg_done pulse with seg_done_quarter=0 (idle released nothing earlier), busy_mask=4'b0010.
- Push q0 while q0 is active → cmd_ready=0. Push q3 → rejected. Push q0,q1,q2 from idle → all accepted, fourth push rejected.
- Queue empty with run=1 at a wrap → underrun_count=1, cfg_data=0xC001. With AXIS_RADAR_SCHED_LOOP_EN: cfg_data keeps the last segment, no seg_done.
- flush on the same cycle as a wrap with 2 queued (q1,q2) → q1 armed, q2 discarded, busy bit 2 cleared next cycle.
